serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. One accepted start loads the two operands into
// right-shifting registers. A single 1-bit full-adder cell then processes one
// bit per cycle, LSB first, for WIDTH cycles. A one-cycle DONE state presents
// the result with a done pulse.
//
// Parameters
//   WIDTH   operand width in bits, 2..64
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   begin one operation; sampled only while idle
//   in_a    operand A, captured with start
//   in_b    operand B, captured with start
//   cin     carry-in, captured with start
//   busy    high while an operation is running or finishing (RUN/DONE)
//   done    one-cycle pulse; sum/cout valid from this cycle on
//   sum     result register, held in IDLE until the next accepted start
//   cout    final carry-out, held like sum
//   sub     (only with SERIAL_ADD_SUB_EN) 1 = compute in_a - in_b
//
// Build option
//   SERIAL_ADD_SUB_EN  when defined, adds the 'sub' port. Subtraction
//   loads ~in_b and forces the initial carry to 1, so that
//   sum = in_a - in_b and cout = 1 means "no borrow".
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// adder_1bit -- single full-adder cell
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
// ---------------------------------------------------------------------------
module adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_SUB_EN
   ,
   input  logic             sub
`endif
);

   // The counter has to hold 0..WIDTH without wrapping.
   localparam int CW = $clog2(WIDTH + 1);
   // The counter value during the cycle that processes the MSB.
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cout_q, cout_d;

   // Operand B and initial carry as loaded on start. They differ from the raw
   // inputs only when subtraction is selected.
   logic [WIDTH-1:0] load_b;
   logic             load_carry;

   // Outputs of the adder cell
   logic             cell_s;
   logic             cell_co;

   // The only arithmetic element. It always looks at the current LSBs.
   adder_1bit u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .s    (cell_s),
      .cout (cell_co)
   );

`ifdef SERIAL_ADD_SUB_EN
   always_comb begin
      load_b     = sub ? ~in_b : in_b;
      load_carry = sub ? 1'b1  : cin;
   end
`else
   always_comb begin
      load_b     = in_b;
      load_carry = cin;
   end
`endif

   // Next-state logic. Every output is registered. busy and done are
   // computed for the state being entered, so they line up with state_q.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = in_a;
               b_d     = load_b;
               carry_d = load_carry;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // The result enters from the MSB side. After WIDTH shifts, bit 0
            // of the result has reached bit 0 of sum.
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {cell_s, sum_q[WIDTH-1:1]};
            carry_d = cell_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               cout_d  = cell_co;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            // Return to IDLE unconditionally. A start seen here is dropped.
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl. It uses a 32-bit instance for the
// named vectors, back-to-back, reset-abort and (optional) subtract cases. It
// uses a 4-bit instance for the exhaustive sweep. Inputs are driven 1 time
// unit after a rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        s_start, s_cin, s_sub;
   logic [31:0] s_a, s_b;
   logic        s_busy, s_done, s_cout;
   logic [31:0] s_sum;

   // 4-bit instance
   logic        t_start, t_cin, t_sub;
   logic [3:0]  t_a, t_b;
   logic        t_busy, t_done, t_cout;
   logic [3:0]  t_sum;

   int n_chk = 0;
   int n_bad = 0;

   serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (s_start),
      .in_a  (s_a),
      .in_b  (s_b),
      .cin   (s_cin),
      .busy  (s_busy),
      .done  (s_done),
      .sum   (s_sum),
      .cout  (s_cout)
`ifdef SERIAL_ADD_SUB_EN
      ,
      .sub   (s_sub)
`endif
   );

   serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (t_start),
      .in_a  (t_a),
      .in_b  (t_b),
      .cin   (t_cin),
      .busy  (t_busy),
      .done  (t_done),
      .sum   (t_sum),
      .cout  (t_cout)
`ifdef SERIAL_ADD_SUB_EN
      ,
      .sub   (t_sub)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Run one 32-bit operation. After acceptance, the operand inputs are
   // scrambled. With rep set, start is pulsed again during RUN.
   task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic sb, input logic rep,
                       input logic [31:0] es, input logic ec);
      int lat, got_lat, pulses, nb;
      @(posedge clk); #1;
      s_start = 1'b1; s_a = a; s_b = b; s_cin = c; s_sub = sb;
      @(posedge clk); #1;                       // edge 0: accepted
      s_start = 1'b0; s_a = ~a; s_b = ~b; s_cin = ~c; s_sub = ~sb;
      lat = 1; got_lat = 0; pulses = 0; nb = 0;
      for (int i = 0; i < 80; i++) begin
         if (rep && i == 5) s_start = 1'b1;
         if (rep && i == 7) s_start = 1'b0;
         if (s_done) begin
            pulses++;
            if (got_lat == 0) got_lat = lat;
         end
         if (!s_busy) break;
         nb++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"},    got_lat, 33);
      chk({tag, ".pulses"}, pulses, 1);
      chk({tag, ".busycyc"}, nb, 33);
      chk({tag, ".sum"},    s_sum, es);
      chk({tag, ".cout"},   s_cout, ec);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".hold"},   {s_cout, s_sum}, {ec, es});
   endtask

   // One 4-bit operation, checked against the 5-bit reference sum
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
      int lat, got_lat;
      logic [4:0] ref5;
      ref5 = {1'b0, a} + {1'b0, b} + {4'b0, c};
      @(posedge clk); #1;
      t_start = 1'b1; t_a = a; t_b = b; t_cin = c;
      @(posedge clk); #1;
      t_start = 1'b0; t_a = ~a; t_b = ~b; t_cin = ~c;
      lat = 1; got_lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (t_done && got_lat == 0) got_lat = lat;
         if (!t_busy) break;
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("w4 %0h+%0h+%0d lat", a, b, c), got_lat, 5);
      chk($sformatf("w4 %0h+%0h+%0d res", a, b, c), {t_cout, t_sum}, ref5);
   endtask

   initial begin
      int dn, low, pulses;
      int d[3];
      s_start = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0;
      t_start = 0; t_a = 0; t_b = 0; t_cin = 0; t_sub = 0;

      // Reset state
      #12;
      chk("rst.busy", s_busy, 0);
      chk("rst.done", s_done, 0);
      chk("rst.sum",  s_sum, 0);
      chk("rst.cout", s_cout, 0);
      chk("rst.w4",   {t_busy, t_done, t_cout, t_sum}, 0);
      @(negedge clk); rst_n = 1'b1;

      // Directed vectors
      op32("ovf",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1);
      op32("rep",   32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b1, 32'h2345678A, 1'b0);
      op32("msb",   32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b1);
      op32("alt",   32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1);
      op32("zero",  32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0);
      op32("mixed", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0);

      // Back-to-back operation with start held high
      @(posedge clk); #1;
      s_start = 1'b1; s_a = 32'd3; s_b = 32'd4; s_cin = 1'b0; s_sub = 1'b0;
      dn = 0; low = 0;
      for (int c = 1; c <= 110; c++) begin
         @(posedge clk); #1;
         if (s_done && dn < 3) begin
            d[dn] = c;
            dn++;
         end
         if (!s_busy && dn >= 1 && dn < 3) low++;
      end
      s_start = 1'b0;
      chk("b2b.ndone", dn, 3);
      chk("b2b.per1",  d[1] - d[0], 34);
      chk("b2b.per2",  d[2] - d[1], 34);
      chk("b2b.idle",  low, 2);
      for (int i = 0; i < 50 && s_busy; i++) begin
         @(posedge clk); #1;
      end
      chk("b2b.drain", s_busy, 0);
      chk("b2b.sum",   {s_cout, s_sum}, {1'b0, 32'd7});

      // Reset asserted while bit 10 is being processed
      @(posedge clk); #1;
      s_start = 1'b1; s_a = 32'h0F0F0F0F; s_b = 32'h01010101; s_cin = 1'b0;
      @(posedge clk); #1;
      s_start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort.busy", s_busy, 0);
      chk("abort.done", s_done, 0);
      chk("abort.sum",  s_sum, 0);
      chk("abort.cout", s_cout, 0);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (s_done || s_busy) pulses++;
      end
      chk("abort.quiet", pulses, 0);
      op32("after", 32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 1'b0, 32'h10101010, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      op32("sub57", 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0);
      op32("sub75", 32'd7, 32'd5, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b1);
`endif

      // Exhaustive sweep of the 4-bit instance
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               op4(4'(a), 4'(b), 1'(c));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Hard stop in case the stimulus stalls
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
